// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter: bus widths, defaults
// and FSM state encodings.
package mem_port_arbiter_pkg;
    localparam int INST_ADDR_BUS_W = 32;
    localparam int REG_BUS_W       = 32;
    localparam int MEM_ARB_TIMEOUT = 64;
    localparam int MEM_ARB_STREAK  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;
endpackage

// File: rtl/mem_arb_timer.sv
// Timeout counter for an outstanding memory access; expired is asserted in the
// TIMEOUT-th cycle after a clear.
module mem_arb_timer import mem_port_arbiter_pkg::*; #(
    parameter int TIMEOUT = MEM_ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single ram_rom port between instruction fetch and the MEM
// stage: data has priority, bounded by a streak guard so fetch cannot starve.
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
    parameter int ADDR_W       = INST_ADDR_BUS_W,
    parameter int DATA_W       = REG_BUS_W,
    parameter int MAX_D_STREAK = MEM_ARB_STREAK,
    parameter int TIMEOUT      = MEM_ARB_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                bus_err,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_sel,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic          busy, done, tmr_exp, gnt_d;

    assign busy  = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    assign done  = busy && (mem_ready || tmr_exp);
    // Data wins unless fetch is waiting and data already used its full streak.
    assign gnt_d = d_req && !(if_req && (streak == SW'(MAX_D_STREAK)));

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_IDLE),
        .en      (busy),
        .expired (tmr_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            streak    <= '0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_d) begin
                        state     <= ST_BUSY_D;
                        mem_ce    <= 1'b1;
                        mem_we    <= d_we;
                        mem_sel   <= d_sel;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // gnt_d with if_req implies streak < MAX, so this saturates.
                        streak    <= if_req ? streak + 1'b1 : '0;
                    end else if (if_req) begin
                        state     <= ST_BUSY_I;
                        mem_ce    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_sel   <= '1;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        streak    <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (done) begin
                        state    <= ST_RESP;
                        mem_ce   <= 1'b0;
                        if_ready <= (state == ST_BUSY_I);
                        d_ready  <= (state == ST_BUSY_D);
                        bus_err  <= !mem_ready;
                        if (mem_ready) begin
                            if (state == ST_BUSY_I)
                                if_rdata <= mem_rdata;
                            else if (!mem_we)
                                d_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
